sad_min_engine: RTL and testbench

- Parametrised successor of the single-lane SAD stage in the 6-stage core; intended to replace the MEM_SAD→SAD_WB SAD path.
- Accepts LANES pixel pairs per beat and accumulates a sum of absolute differences over a multi-beat candidate block.
- Tracks the running minimum SAD and its candidate tag across one search, and reports per-candidate results with valid/ready backpressure.

---
 rtl/sad_pkg.sv | 25 ++
 rtl/sad_lane_tree.sv | 43 ++++
 rtl/sad_min_engine.sv | 188 ++++++++++++++++++
 tb/tb_sad_min_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared types, default sizes and arithmetic helpers for the SAD minimum-search engine.
package sad_pkg;

    typedef enum logic [1:0] {IDLE, SEARCH, DRAIN} state_t;

    localparam int DEF_LANES = 4;
    localparam int DEF_PIX_W = 8;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_TAG_W = 16;
    localparam int SUM_W     = DEF_PIX_W + $clog2(DEF_LANES);

    function automatic int sum_width(input int pix_w, input int lanes);
        return pix_w + $clog2(lanes);
    endfunction

    // Unsigned add clamped to the all-ones value of a w-bit field (w up to 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [63:0] lim;
        logic [64:0] s;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        s   = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[63:0];
    endfunction

endpackage

// File: rtl/sad_lane_tree.sv
// S1/S2 data path: registered per-lane absolute differences followed by a registered lane-sum tree.
module sad_lane_tree
    import sad_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int TREE_W = SUM_W
) (
    input  logic                   Clk,
    input  logic                   en,
    input  logic [LANES*PIX_W-1:0] a,
    input  logic [LANES*PIX_W-1:0] b,
    output logic [TREE_W-1:0]      sum
);

    logic [PIX_W-1:0]  diff [LANES];
    logic [TREE_W-1:0] tree_sum;

    always_ff @(posedge Clk) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                diff[i] <= (a[i*PIX_W +: PIX_W] > b[i*PIX_W +: PIX_W])
                         ? a[i*PIX_W +: PIX_W] - b[i*PIX_W +: PIX_W]
                         : b[i*PIX_W +: PIX_W] - a[i*PIX_W +: PIX_W];
            end
        end
    end

    // Width TREE_W cannot overflow for LANES values of PIX_W bits.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + TREE_W'(diff[i]);
        end
    end

    always_ff @(posedge Clk) begin
        if (en) begin
            sum <= tree_sum;
        end
    end

endmodule

// File: rtl/sad_min_engine.sv
// Candidate framing, saturating accumulator, running-minimum tracking, search FSM and handshakes.
// Defining SAD_EARLY_TERM_EN enables pruning of candidates that already exceed the minimum.
module sad_min_engine
    import sad_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int PIX_W = DEF_PIX_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   search_start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic                   in_final,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [LANES*PIX_W-1:0] in_a,
    input  logic [LANES*PIX_W-1:0] in_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACC_W-1:0]       res_sad,
    output logic [TAG_W-1:0]       res_tag,
    output logic                   res_is_min,
    output logic [ACC_W-1:0]       min_sad,
    output logic [TAG_W-1:0]       min_tag,
`ifdef SAD_EARLY_TERM_EN
    output logic                   res_pruned,
`endif
    output logic                   done,
    output logic                   proto_err
);

    localparam int TREE_W = sum_width(PIX_W, LANES);

    state_t state, state_next;

    logic advance, accept, keep, frame_err, beat_final, result_taken, new_min;
    logic cand_open;
    logic s1_valid, s1_first, s1_last, s1_final;
    logic s2_valid, s2_first, s2_last, s2_final;
    logic [TAG_W-1:0] s1_tag, s2_tag, acc_tag;
    logic [TREE_W-1:0] tree_sum;
    logic [ACC_W-1:0] acc, acc_next, sum_ext;
    logic acc_done, acc_final, res_final;
`ifdef SAD_EARLY_TERM_EN
    logic pruned, prune_now;
`endif

    sad_lane_tree #(.LANES(LANES), .PIX_W(PIX_W), .TREE_W(TREE_W)) u_tree (
        .Clk (Clk),
        .en  (advance),
        .a   (in_a),
        .b   (in_b),
        .sum (tree_sum)
    );

    assign advance      = ~(res_valid & ~res_ready);
    assign in_ready     = advance & (state == SEARCH);
    assign accept       = in_valid & in_ready & ~search_start;
    assign keep         = accept & (in_first | cand_open);
    // Error when a first beat lands on an open candidate, or a continuation beat on none.
    assign frame_err    = accept & (in_first == cand_open);
    assign beat_final   = keep & in_last & in_final;
    assign result_taken = res_valid & res_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            SEARCH:  if (beat_final) state_next = DRAIN;
            DRAIN:   if (result_taken && res_final) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (search_start) state_next = SEARCH;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge Clk) begin
        if (!Reset || search_start) begin
            cand_open <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            acc_done  <= 1'b0;
            res_valid <= 1'b0;
        end else if (advance) begin
            if (keep) cand_open <= ~in_last;
            s1_valid  <= keep;
            s2_valid  <= s1_valid;
            acc_done  <= s2_valid & s2_last;
            res_valid <= acc_done;
        end
    end

    always_ff @(posedge Clk) begin
        if (advance) begin
            s1_first  <= in_first;
            s1_last   <= in_last;
            s1_final  <= in_final & in_last;
            s1_tag    <= in_tag;
            s2_first  <= s1_first;
            s2_last   <= s1_last;
            s2_final  <= s1_final;
            s2_tag    <= s1_tag;
            acc_final <= s2_final;
        end
    end

    always_comb begin
        sum_ext  = ACC_W'(tree_sum);
        acc_next = s2_first ? sum_ext : ACC_W'(sat_add(64'(acc), 64'(sum_ext), ACC_W));
    end

`ifdef SAD_EARLY_TERM_EN
    assign prune_now = ~s2_last & (acc_next > min_sad);
    assign new_min   = ~pruned & (acc < min_sad);
`else
    assign new_min   = acc < min_sad;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset || search_start) begin
            acc     <= '0;
            acc_tag <= '0;
`ifdef SAD_EARLY_TERM_EN
            pruned  <= 1'b0;
`endif
        end else if (advance && s2_valid) begin
`ifdef SAD_EARLY_TERM_EN
            // A pruned candidate freezes its accumulator until the next first beat.
            if (s2_first || !pruned) begin
                acc    <= acc_next;
                pruned <= prune_now;
            end
`else
            acc <= acc_next;
`endif
            if (s2_first) acc_tag <= s2_tag;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            res_sad    <= '0;
            res_tag    <= '0;
            res_is_min <= 1'b0;
            res_final  <= 1'b0;
            min_sad    <= '1;
            min_tag    <= '0;
`ifdef SAD_EARLY_TERM_EN
            res_pruned <= 1'b0;
`endif
        end else if (search_start) begin
            min_sad <= '1;
            min_tag <= '0;
        end else if (advance && acc_done) begin
            res_sad    <= acc;
            res_tag    <= acc_tag;
            res_is_min <= new_min;
            res_final  <= acc_final;
`ifdef SAD_EARLY_TERM_EN
            res_pruned <= pruned;
`endif
            if (new_min) begin
                min_sad <= acc;
                min_tag <= acc_tag;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            done      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            done <= (state == DRAIN) & result_taken & res_final & ~search_start;
            if (search_start)   proto_err <= 1'b0;
            else if (frame_err) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sad_min_engine.sv
// Directed bench for sad_min_engine with hand-computed SADs; the pruning scenario
// is compiled only when SAD_EARLY_TERM_EN is defined.
module tb_sad_min_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        search_start;
    logic        in_valid, in_ready, in_first, in_last, in_final;
    logic [15:0] in_tag;
    logic [31:0] in_a, in_b;
    logic        res_valid, res_ready, res_is_min, done, proto_err;
    logic [31:0] res_sad, min_sad;
    logic [15:0] res_tag, min_tag;
`ifdef SAD_EARLY_TERM_EN
    logic        res_pruned;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sad_min_engine dut (
        .Clk          (clk),
        .Reset        (reset_n),
        .search_start (search_start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_first     (in_first),
        .in_last      (in_last),
        .in_final     (in_final),
        .in_tag       (in_tag),
        .in_a         (in_a),
        .in_b         (in_b),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_sad      (res_sad),
        .res_tag      (res_tag),
        .res_is_min   (res_is_min),
        .min_sad      (min_sad),
        .min_tag      (min_tag),
`ifdef SAD_EARLY_TERM_EN
        .res_pruned   (res_pruned),
`endif
        .done         (done),
        .proto_err    (proto_err)
    );

    function automatic logic [31:0] pk(input int x0, input int x1, input int x2, input int x3);
        return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_search();
        search_start = 1'b1;
        tick();
        search_start = 1'b0;
    endtask

    task automatic send_beat(input bit first, input bit last, input bit fin,
                             input logic [15:0] tag, input logic [31:0] a, input logic [31:0] b);
        int waitc;
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        in_final = fin;
        in_tag   = tag;
        in_a     = a;
        in_b     = b;
        waitc    = 0;
        while (!in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL send_ready_timeout in_ready=%0b required=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_final = 1'b0;
    endtask

    task automatic wait_res(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < 12) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got=%0b exp=0", res_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%0b exp=0", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%0b exp=0", done); end
        checks++; if (res_sad !== 32'h0 || res_tag !== 16'h0) begin errors++; $display("[TB] FAIL reset_res_data got=%0h/%0h exp=0/0", res_sad, res_tag); end
        checks++; if (min_sad !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_min_sad got=%0h exp=ffffffff", min_sad); end
        checks++; if (min_tag !== 16'h0) begin errors++; $display("[TB] FAIL reset_min_tag got=%0h exp=0", min_tag); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto_err got=%0b exp=0", proto_err); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_one_beat();
        int cyc;
        start_search();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL search_in_ready got=%0b exp=1", in_ready); end
        send_beat(1, 1, 0, 16'h0101, pk(10, 20, 30, 40), pk(12, 18, 30, 45));
        wait_res(cyc);
        checks++; if (cyc != 3) begin errors++; $display("[TB] FAIL one_beat_latency got=%0d exp=3", cyc); end
        checks++; if (res_sad !== 32'd9) begin errors++; $display("[TB] FAIL one_beat_sad got=%0d exp=9", res_sad); end
        checks++; if (res_tag !== 16'h0101 || res_is_min !== 1'b1) begin errors++; $display("[TB] FAIL one_beat_tag_min got=%0h/%0b exp=0101/1", res_tag, res_is_min); end
        checks++; if (min_sad !== 32'd9 || min_tag !== 16'h0101) begin errors++; $display("[TB] FAIL one_beat_minimum got=%0d/%0h exp=9/0101", min_sad, min_tag); end
        tick();
    endtask

    task automatic test_two_beat();
        int cyc;
        send_beat(1, 0, 0, 16'h0202, pk(10, 20, 30, 40), pk(12, 18, 30, 45));
        send_beat(0, 1, 0, 16'h0000, pk(0, 0, 0, 0), pk(1, 1, 1, 1));
        wait_res(cyc);
        checks++; if (res_valid !== 1'b1 || res_sad !== 32'd13) begin errors++; $display("[TB] FAIL two_beat_sad got=%0d valid=%0b exp=13", res_sad, res_valid); end
        checks++; if (res_tag !== 16'h0202 || res_is_min !== 1'b0) begin errors++; $display("[TB] FAIL two_beat_tag_min got=%0h/%0b exp=0202/0", res_tag, res_is_min); end
        checks++; if (min_sad !== 32'd9 || min_tag !== 16'h0101) begin errors++; $display("[TB] FAIL two_beat_minimum got=%0d/%0h exp=9/0101", min_sad, min_tag); end
        tick();
        send_beat(1, 1, 0, 16'h0303, pk(10, 20, 30, 40), pk(12, 18, 30, 45));
        wait_res(cyc);
        checks++; if (res_valid !== 1'b1 || res_sad !== 32'd9 || res_is_min !== 1'b0) begin errors++; $display("[TB] FAIL tie_result got=%0d/%0b exp=9/0", res_sad, res_is_min); end
        checks++; if (min_tag !== 16'h0101) begin errors++; $display("[TB] FAIL tie_min_tag got=%0h exp=0101", min_tag); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit saw;
        logic [31:0] e_sad [3] = '{32'd5, 32'd7, 32'd3};
        logic [15:0] e_tag [3] = '{16'h0A01, 16'h0A02, 16'h0A03};
        logic        e_min [3] = '{1'b1, 1'b0, 1'b1};
        start_search();
        res_ready = 1'b0;
        send_beat(1, 1, 0, 16'h0A01, pk(5, 0, 0, 0), pk(0, 0, 0, 0));
        send_beat(1, 1, 0, 16'h0A02, pk(1, 2, 3, 1), pk(0, 0, 0, 0));
        send_beat(1, 1, 0, 16'h0A03, pk(0, 0, 0, 0), pk(1, 1, 1, 0));
        wait_res(cyc);
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_tag = 16'h0AFF;
        in_a = pk(9, 9, 9, 9); in_b = pk(0, 0, 0, 0);
        for (int h = 0; h < 5; h++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready cycle=%0d got=%0b exp=0", h, in_ready); end
            checks++; if (res_valid !== 1'b1 || res_sad !== 32'd5 || res_tag !== 16'h0A01) begin errors++; $display("[TB] FAIL stall_hold cycle=%0d got=%0b/%0d/%0h exp=1/5/0a01", h, res_valid, res_sad, res_tag); end
            tick();
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_res(cyc);
            checks++;
            if (res_valid !== 1'b1 || res_sad !== e_sad[k] || res_tag !== e_tag[k] || res_is_min !== e_min[k]) begin
                errors++;
                $display("[TB] FAIL drain_order idx=%0d got=%0b/%0d/%0h/%0b exp=1/%0d/%0h/%0b",
                         k, res_valid, res_sad, res_tag, res_is_min, e_sad[k], e_tag[k], e_min[k]);
            end
            tick();
        end
        saw = 0;
        for (int c = 0; c < 5; c++) begin
            if (res_valid) saw = 1;
            tick();
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("[TB] FAIL stall_extra_result got=%0b exp=0", saw); end
        checks++; if (min_sad !== 32'd3 || min_tag !== 16'h0A03) begin errors++; $display("[TB] FAIL stall_minimum got=%0d/%0h exp=3/0a03", min_sad, min_tag); end
    endtask

    task automatic test_search_end();
        int got, done_cnt, done_cyc, final_cyc;
        logic [31:0] e_sad [3] = '{32'd10, 32'd510, 32'd4};
        logic [15:0] e_tag [3] = '{16'h0B01, 16'h0B02, 16'h0B03};
        logic        e_min [3] = '{1'b1, 1'b0, 1'b1};
        start_search();
        send_beat(1, 1, 0, 16'h0B01, pk(200, 0, 0, 0), pk(190, 0, 0, 0));
        send_beat(1, 0, 0, 16'h0B02, pk(255, 0, 0, 0), pk(0, 0, 0, 0));
        send_beat(0, 1, 0, 16'h0000, pk(0, 0, 0, 0), pk(0, 0, 0, 255));
        send_beat(1, 1, 1, 16'h0B03, pk(0, 0, 0, 0), pk(1, 1, 1, 1));
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL drain_in_ready got=%0b exp=0", in_ready); end
        got = 0; done_cnt = 0; done_cyc = -1; final_cyc = -1;
        for (int c = 0; c < 12; c++) begin
            if (res_valid) begin
                if (got < 3) begin
                    checks++;
                    if (res_sad !== e_sad[got] || res_tag !== e_tag[got] || res_is_min !== e_min[got]) begin
                        errors++;
                        $display("[TB] FAIL end_result idx=%0d got=%0d/%0h/%0b exp=%0d/%0h/%0b",
                                 got, res_sad, res_tag, res_is_min, e_sad[got], e_tag[got], e_min[got]);
                    end
                end
                if (res_tag == 16'h0B03) final_cyc = c;
                got++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            tick();
        end
        checks++; if (got != 3) begin errors++; $display("[TB] FAIL end_result_count got=%0d exp=3", got); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL done_pulse_count got=%0d exp=1", done_cnt); end
        checks++; if (final_cyc < 0 || done_cyc != final_cyc + 1) begin errors++; $display("[TB] FAIL done_timing got=%0d exp=%0d", done_cyc, final_cyc + 1); end
        checks++; if (min_sad !== 32'd4 || min_tag !== 16'h0B03) begin errors++; $display("[TB] FAIL end_minimum got=%0d/%0h exp=4/0b03", min_sad, min_tag); end
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_in_ready got=%0b exp=0", in_ready); end
        start_search();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL restart_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_framing();
        int cyc;
        bit saw;
        start_search();
        send_beat(0, 0, 0, 16'h0C00, pk(9, 9, 9, 9), pk(0, 0, 0, 0));
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL orphan_proto_err got=%0b exp=1", proto_err); end
        send_beat(0, 1, 0, 16'h0C00, pk(9, 9, 9, 9), pk(0, 0, 0, 0));
        saw = 0;
        for (int c = 0; c < 6; c++) begin
            if (res_valid) saw = 1;
            tick();
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("[TB] FAIL orphan_dropped got=%0b exp=0", saw); end

        start_search();
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL restart_proto_err got=%0b exp=0", proto_err); end
        send_beat(1, 0, 0, 16'h0C01, pk(10, 20, 30, 40), pk(12, 18, 30, 45));
        send_beat(1, 1, 0, 16'h0C02, pk(0, 0, 0, 0), pk(1, 1, 1, 1));
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL abandon_proto_err got=%0b exp=1", proto_err); end
        wait_res(cyc);
        checks++; if (res_valid !== 1'b1 || res_sad !== 32'd4 || res_tag !== 16'h0C02) begin errors++; $display("[TB] FAIL abandon_result got=%0b/%0d/%0h exp=1/4/0c02", res_valid, res_sad, res_tag); end
        tick();
        saw = 0;
        for (int c = 0; c < 5; c++) begin
            if (res_valid) saw = 1;
            tick();
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("[TB] FAIL abandon_no_extra got=%0b exp=0", saw); end

        start_search();
        send_beat(1, 1, 0, 16'h0C03, pk(10, 20, 30, 40), pk(12, 18, 30, 45));
        wait_res(cyc);
        tick();
        send_beat(0, 0, 0, 16'h0C00, pk(1, 1, 1, 1), pk(0, 0, 0, 0));
        send_beat(1, 1, 0, 16'h0C04, pk(1, 1, 1, 1), pk(0, 0, 0, 0));
        send_beat(1, 0, 0, 16'h0C05, pk(1, 1, 1, 1), pk(0, 0, 0, 0));
        start_search();
        saw = 0;
        for (int c = 0; c < 6; c++) begin
            if (res_valid) saw = 1;
            tick();
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_result got=%0b exp=0", saw); end
        checks++; if (min_sad !== 32'hFFFF_FFFF || min_tag !== 16'h0) begin errors++; $display("[TB] FAIL flush_minimum got=%0h/%0h exp=ffffffff/0", min_sad, min_tag); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL flush_proto_err got=%0b exp=0", proto_err); end
        send_beat(0, 1, 0, 16'h0C00, pk(1, 1, 1, 1), pk(0, 0, 0, 0));
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL flush_closes_candidate got=%0b exp=1", proto_err); end
    endtask

    task automatic test_reset_mid_search();
        int cyc;
        bit saw;
        start_search();
        send_beat(1, 1, 0, 16'h0D01, pk(10, 20, 30, 40), pk(12, 18, 30, 45));
        wait_res(cyc);
        tick();
        send_beat(0, 0, 0, 16'h0D00, pk(1, 1, 1, 1), pk(0, 0, 0, 0));
        send_beat(1, 1, 0, 16'h0D02, pk(0, 0, 0, 0), pk(1, 1, 1, 1));
        reset_n = 1'b0;
        tick();
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ctrl got=%0b/%0b/%0b exp=0/0/0", res_valid, in_ready, done); end
        checks++; if (res_sad !== 32'h0 || res_tag !== 16'h0) begin errors++; $display("[TB] FAIL midreset_res_data got=%0h/%0h exp=0/0", res_sad, res_tag); end
        checks++; if (min_sad !== 32'hFFFF_FFFF || min_tag !== 16'h0 || proto_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_min_err got=%0h/%0h/%0b exp=ffffffff/0/0", min_sad, min_tag, proto_err); end
        reset_n = 1'b1;
        saw = 0;
        for (int c = 0; c < 6; c++) begin
            if (res_valid) saw = 1;
            tick();
        end
        checks++; if (saw !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_discard got=%0b/%0b exp=0/0", saw, in_ready); end
    endtask

`ifdef SAD_EARLY_TERM_EN
    task automatic test_pruning();
        int cyc;
        start_search();
        send_beat(1, 1, 0, 16'h0E01, pk(10, 20, 30, 40), pk(12, 18, 30, 45));
        wait_res(cyc);
        tick();
        send_beat(1, 0, 0, 16'h0E02, pk(2, 2, 2, 2), pk(0, 0, 0, 0));
        send_beat(0, 0, 0, 16'h0000, pk(2, 2, 2, 2), pk(0, 0, 0, 0));
        send_beat(0, 0, 0, 16'h0000, pk(2, 2, 2, 2), pk(0, 0, 0, 0));
        send_beat(0, 1, 0, 16'h0000, pk(2, 2, 2, 2), pk(0, 0, 0, 0));
        wait_res(cyc);
        checks++; if (res_valid !== 1'b1 || res_pruned !== 1'b1 || res_sad !== 32'd16) begin errors++; $display("[TB] FAIL prune_result got=%0b/%0b/%0d exp=1/1/16", res_valid, res_pruned, res_sad); end
        checks++; if (res_is_min !== 1'b0 || min_sad !== 32'd9 || min_tag !== 16'h0E01) begin errors++; $display("[TB] FAIL prune_minimum got=%0b/%0d/%0h exp=0/9/0e01", res_is_min, min_sad, min_tag); end
        tick();
    endtask
`endif

    initial begin
        reset_n      = 1'b0;
        search_start = 1'b0;
        in_valid     = 1'b0;
        in_first     = 1'b0;
        in_last      = 1'b0;
        in_final     = 1'b0;
        in_tag       = '0;
        in_a         = '0;
        in_b         = '0;
        res_ready    = 1'b1;
        test_reset();
        test_one_beat();
        test_two_beat();
        test_back_to_back();
        test_search_end();
        test_framing();
        test_reset_mid_search();
`ifdef SAD_EARLY_TERM_EN
        reset_n = 1'b1;
        test_pruning();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
